entrada_io: RTL and testbench

- Processor-side input port; counterpart to the data-memory output register that `otflag` loads.
- On an input instruction (`inflag`), stalls the core until the user sets the switches and presses a confirm button.
- Then delivers the zero-extended switch value as a 32-bit word for the register-file write-back mux.
- Contains the button synchroniser, debouncer and request handshake FSM.

---
 rtl/io_pkg.sv | 14 +
 rtl/input_debounce.sv | 51 +++++
 rtl/entrada_io.sv | 85 ++++++++
 tb/tb_entrada_io.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/io_pkg.sv
// Shared types and constants for the processor input port.
package io_pkg;

  localparam int unsigned DATA_W                  = 32;
  localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 50000;

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_WAIT_PRESS   = 2'd1,
    ST_CAPTURE      = 2'd2,
    ST_WAIT_RELEASE = 2'd3
  } state_e;

endpackage

// File: rtl/input_debounce.sv
// Two-flop synchroniser plus counter debouncer for an asynchronous push button.
// rise_pulse flags the edge on which the debounced level goes high.
module input_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned CNT_W           = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic rise_pulse
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q;
  logic             btn_s_q;
  logic             level_q, level_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Counter only runs while the synchronised input disagrees with the accepted level.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    if (btn_s_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = ~level_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      btn_s_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw;
      btn_s_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level      = level_q;
  assign rise_pulse = level_d & ~level_q;

endmodule

// File: rtl/entrada_io.sv
// Processor input port: stalls the core on an input instruction until a
// debounced button press, then presents the zero-extended switch word.
module entrada_io
  import io_pkg::*;
#(
  parameter int unsigned SW_W            = 16,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int unsigned CNT_W           = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              inflag,
  input  logic [SW_W-1:0]   switches,
  input  logic              enter,
  output logic              halt,
  output logic [DATA_W-1:0] dados_entrada,
  output logic              in_valid
);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] dados_q, dados_d;
  logic              in_valid_q, in_valid_d;
  logic              btn_db;
  logic              press;

  input_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_debounce (
    .clock      (clock),
    .reset      (reset),
    .raw        (enter),
    .level      (btn_db),
    .rise_pulse (press)
  );

  // Request handshake; a press outside WAIT_PRESS is dropped, never buffered.
  always_comb begin
    state_d    = state_q;
    dados_d    = dados_q;
    in_valid_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (inflag) state_d = ST_WAIT_PRESS;
      end
      ST_WAIT_PRESS: begin
        if (press) begin
          state_d    = ST_CAPTURE;
          dados_d    = DATA_W'(switches);
          in_valid_d = 1'b1;
        end
      end
      ST_CAPTURE: begin
        state_d = ST_WAIT_RELEASE;
      end
      ST_WAIT_RELEASE: begin
        if (!btn_db) state_d = inflag ? ST_WAIT_PRESS : ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      dados_q    <= '0;
      in_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      dados_q    <= dados_d;
      in_valid_q <= in_valid_d;
    end
  end

  // Same-cycle stall: a new request must stop the PC before the next edge.
  assign halt = !reset &&
                (((state_q == ST_IDLE || state_q == ST_WAIT_RELEASE) && inflag) ||
                 (state_q == ST_WAIT_PRESS));

  assign dados_entrada = dados_q;
  assign in_valid      = in_valid_q;

endmodule

// File: tb/tb_entrada_io.sv
// Randomised scoreboard bench for entrada_io (16-bit and 8-bit switch variants).
module tb_entrada_io;

  localparam int unsigned DEB = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        inflag;
  logic        enter;
  logic [15:0] switches;
  logic        halt, in_valid;
  logic [31:0] dados;
  logic        halt8, in_valid8;
  logic [31:0] dados8;

  always #5 clock = ~clock;

  entrada_io #(.SW_W(16), .DEBOUNCE_CYCLES(DEB), .CNT_W(3)) u_dut (
    .clock         (clock),
    .reset         (reset),
    .inflag        (inflag),
    .switches      (switches),
    .enter         (enter),
    .halt          (halt),
    .dados_entrada (dados),
    .in_valid      (in_valid)
  );

  entrada_io #(.SW_W(8), .DEBOUNCE_CYCLES(DEB), .CNT_W(3)) u_dut8 (
    .clock         (clock),
    .reset         (reset),
    .inflag        (inflag),
    .switches      (switches[7:0]),
    .enter         (enter),
    .halt          (halt8),
    .dados_entrada (dados8),
    .in_valid      (in_valid8)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: request pending / waiting for release / one-cycle strobe.
  bit          m_s1, m_s2, m_db, m_wait, m_hold, m_strobe, m_retired;
  bit          m_btn_s, m_db_pre, m_press;
  int          m_run;
  logic [31:0] m_word;
  logic [31:0] exp_q[$];

  function automatic bit model_halt();
    return m_wait || (inflag && !m_strobe);
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_s1 = 0; m_s2 = 0; m_db = 0; m_run = 0;
      m_wait = 0; m_hold = 0; m_strobe = 0; m_retired = 0;
      m_word = '0;
      exp_q.delete();
    end else begin
      m_retired = inflag && !model_halt();
      m_btn_s   = m_s2;
      m_s2      = m_s1;
      m_s1      = enter;
      m_db_pre  = m_db;
      m_press   = 0;
      if (m_btn_s == m_db) m_run = 0;
      else begin
        m_run++;
        if (m_run == DEB) begin
          m_db    = !m_db;
          m_run   = 0;
          m_press = m_db;
        end
      end
      if (m_strobe) begin
        m_strobe = 0;
        m_hold   = 1;
      end else if (m_wait) begin
        if (m_press) begin
          m_word   = {16'h0000, switches};
          exp_q.push_back(m_word);
          m_strobe = 1;
          m_wait   = 0;
        end
      end else if (m_hold) begin
        if (!m_db_pre) begin
          m_hold = 0;
          m_wait = inflag;
        end
      end else if (inflag) begin
        m_wait = 1;
      end
    end
  end

  // Monitor: compares outputs against the model away from the active edge.
  always @(negedge clock) begin
    if (!reset) begin
      chk("in_valid", 32'(in_valid), 32'(m_strobe));
      chk("halt", 32'(halt), 32'(model_halt()));
      chk("dados_hold", dados, m_word);
      chk("in_valid8", 32'(in_valid8), 32'(m_strobe));
      chk("halt8", 32'(halt8), 32'(model_halt()));
      chk("dados8", dados8, {24'h0, m_word[7:0]});
      if (in_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid actual=%h required=none t=%0t", dados, $time);
        end else begin
          logic [31:0] e;
          e = exp_q.pop_front();
          chk("capture", dados, e);
        end
      end
    end
  end

  bit want_req = 0;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
      if (!inflag || m_retired) inflag = want_req;
    end
  endtask

  task automatic request();
    want_req = 1;
    step(1);
    want_req = 0;
  endtask

  task automatic press_btn(input int hi, input int lo);
    enter = 1;
    step(hi);
    enter = 0;
    step(lo);
  endtask

  int hold_left = 0;

  initial begin
    reset = 1; inflag = 0; enter = 0; switches = '0;
    #3;
    chk("rst_halt", 32'(halt), 32'h0);
    chk("rst_valid", 32'(in_valid), 32'h0);
    chk("rst_dados", dados, 32'h0);
    @(negedge clock);
    reset = 0;
    step(2);

    switches = 16'hBEEF;
    request();
    step(9);
    press_btn(20, 10);

    request();
    step(3);
    press_btn(3, 5);
    press_btn(3, 10);
    switches = 16'h1234;
    press_btn(12, 10);

    switches = 16'hA5A5;
    request();
    step(2);
    enter = 1;
    step(14);
    request();
    step(10);
    switches = 16'h0001;
    enter = 0;
    step(10);
    press_btn(12, 10);

    switches = 16'h5A5A;
    press_btn(12, 10);
    request();
    step(10);
    switches = 16'h7777;
    press_btn(12, 10);

    request();
    step(2);
    enter = 1; step(2);
    enter = 0; step(1);
    enter = 1; step(1);
    @(negedge clock);
    #2 reset = 1;
    #1;
    chk("rst_mid_halt", 32'(halt), 32'h0);
    chk("rst_mid_valid", 32'(in_valid), 32'h0);
    chk("rst_mid_dados", dados, 32'h0);
    chk("rst_mid_dados8", dados8, 32'h0);
    inflag = 0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 0;
    step(12);
    enter = 0;
    step(10);
    switches = 16'hC0DE;
    request();
    step(4);
    switches = 16'h00FF;
    press_btn(12, 10);

    for (int i = 0; i < 3000; i++) begin
      switches = 16'($urandom);
      want_req = ($urandom_range(0, 7) == 0);
      if (hold_left == 0) begin
        enter     = 1'($urandom_range(0, 1));
        hold_left = $urandom_range(1, 12);
      end
      hold_left--;
      step(1);
    end
    want_req = 0;
    enter    = 0;
    step(30);
    chk("pending_words", 32'(exp_q.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
